io_out_buf: RTL

Output-side write buffer that sits directly downstream of `core`. It captures every output-port write (`out_en` strobe with `addr_out`/`data_out`) into a small FIFO. It presents the writes one at a time to a slower external peripheral over a valid/ready handshake. The core cannot stall, so writes arriving while the buffer is full are dropped and flagged with a sticky overflow bit.

---
 rtl/io_out_buf.sv | 84 ++++++++
 1 files changed

// File: rtl/io_out_buf.sv
// Output-side write buffer: captures core output-port writes into a FIFO and
// presents them show-ahead to a slower peripheral; writes into a full buffer are dropped.
module io_out_buf #(
  parameter int NUBITS = 32,
  parameter int NUIOOU = 8,
  parameter int NBADDR = (NUIOOU > 1) ? $clog2(NUIOOU) : 1,
  parameter int FDEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      out_en,
  input  logic [NBADDR-1:0]         addr_out,
  input  logic [NUBITS-1:0]         data_out,
  output logic                      ext_valid,
  input  logic                      ext_ready,
  output logic [NBADDR-1:0]         ext_addr,
  output logic [NUBITS-1:0]         ext_data,
  output logic [$clog2(FDEPTH):0]   count,
  output logic                      full,
  output logic                      empty,
  output logic                      ovf,
  input  logic                      ovf_clr
);

  localparam int PW = $clog2(FDEPTH);
  localparam int CW = PW + 1;
  localparam int WW = NBADDR + NUBITS;

  logic [WW-1:0]     mem [FDEPTH];
  logic [PW-1:0]     wp;
  logic [PW-1:0]     rp;
  logic [CW-1:0]     count_q;
  logic              ovf_q;
  logic              push;
  logic              pop;
  logic              drop;
  logic [NBADDR-1:0] addr_in;

  // A single-port configuration carries no meaningful address.
  assign addr_in = (NUIOOU > 1) ? addr_out : '0;

  assign full      = (count_q == CW'(FDEPTH));
  assign empty     = (count_q == '0);
  assign ext_valid = ~empty;
  assign count     = count_q;
  assign ovf       = ovf_q;

  assign pop  = ext_valid & ext_ready;
  assign push = out_en & (~full | pop);
  assign drop = out_en & full & ~pop;

  assign {ext_addr, ext_data} = mem[rp];

  // Storage array is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= {addr_in, data_out};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A drop wins over a simultaneous clear.
      ovf_q <= (ovf_q & ~ovf_clr) | drop;
    end
  end

endmodule
